// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_pkg;

    localparam int DATA_W = 32;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    localparam logic [1:0] WB_BUBBLE = 2'b00;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_e;

    // MEM/WB latch contents.
    typedef struct packed {
        logic [1:0]        wb_ctl;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] alu_result;
        logic [4:0]        write_reg;
    } mem_wb_t;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data RAM: synchronous write, combinational read, no reset.
// Latency: store commits at the edge, read data follows addr within the cycle.
// Backpressure: none; the caller sequences the write enable.
module data_memory
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_array [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_array[addr] <= wdata;
        end
    end

    assign rdata = mem_array[addr];

endmodule

// File: rtl/i_memory.sv
// MEM stage: data load/store with MEM_LATENCY-cycle access FSM, pcsrc to fetch, MEM/WB latch.
// Latency: MEM_LATENCY cycles per access, one cycle otherwise; stall high for the first MEM_LATENCY-1.
// Backpressure: stall holds upstream, MEM/WB takes bubbles meanwhile. MEM_ALIGN_CHECK_EN adds mem_misaligned.
module i_memory
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        wb_ctl,
    input  logic              branch,
    input  logic              memread,
    input  logic              memwrite,
    input  logic              zero,
    input  logic [DATA_W-1:0] EX_MEM_NPC,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] rdata2out,
    input  logic [4:0]        five_bit_muxout,
    output logic              pcsrc,
    output logic [DATA_W-1:0] branch_target,
    output logic              stall,
    output logic [1:0]        mem_wb_ctl,
    output logic [DATA_W-1:0] mem_read_data,
    output logic [DATA_W-1:0] mem_alu_result,
`ifdef MEM_ALIGN_CHECK_EN
    output logic [4:0]        mem_write_reg,
    output logic              mem_misaligned
`else
    output logic [4:0]        mem_write_reg
`endif
);

    localparam int CNT_W = $clog2(MEM_LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (MEM_LATENCY > 1) ? CNT_W'(MEM_LATENCY - 2) : '0;

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mem_wb_t           wb_q, wb_d;

    logic [ADDR_W-1:0] word_addr;
    logic [DATA_W-1:0] rd_data;
    logic              access;
    logic              misaligned;
    logic              stall_c;
    logic              complete;
    logic              mem_we;

    assign word_addr = alu_result[ADDR_W+1:2];
    assign access    = memread | memwrite;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = access & (alu_result[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign pcsrc         = branch & zero;
    assign branch_target = EX_MEM_NPC;

    // complete marks the edge at which the current instruction retires into MEM/WB.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_c  = 1'b0;
        complete = 1'b1;
        if (MEM_LATENCY > 1) begin
            unique case (state_q)
                IDLE: begin
                    if (access && !misaligned) begin
                        stall_c  = 1'b1;
                        complete = 1'b0;
                        state_d  = BUSY;
                        cnt_d    = CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        stall_c  = 1'b1;
                        complete = 1'b0;
                        cnt_d    = cnt_q - CNT_W'(1);
                    end else begin
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A store presented while reset is held must not reach the array.
    assign mem_we = complete & memwrite & ~misaligned & ~rst;
    assign stall  = stall_c & ~rst;

    always_comb begin
        wb_d        = wb_q;
        wb_d.wb_ctl = WB_BUBBLE;
        if (complete) begin
            wb_d.wb_ctl     = wb_ctl;
            wb_d.read_data  = misaligned ? '0 : rd_data;
            wb_d.alu_result = alu_result;
            wb_d.write_reg  = five_bit_muxout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wb_q    <= wb_d;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned_q, misaligned_d;

    assign misaligned_d = complete & misaligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end

    assign mem_misaligned = misaligned_q;
`endif

    data_memory #(
        .ADDR_W (ADDR_W)
    ) u_data_memory (
        .clk   (clk),
        .we    (mem_we),
        .addr  (word_addr),
        .wdata (rdata2out),
        .rdata (rd_data)
    );

    assign mem_wb_ctl     = wb_q.wb_ctl;
    assign mem_read_data  = wb_q.read_data;
    assign mem_alu_result = wb_q.alu_result;
    assign mem_write_reg  = wb_q.write_reg;

endmodule
